execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Execute (EX) stage of the 5-stage RV32I pipeline, between ID/EX and MEM.
- Selects forwarded operands and runs the ALU.
- Resolves branches combinationally and computes the branch target.
- Registers control signals and results into the EX/MEM pipeline register.

Parameters:
- None. Data width is fixed at 32 bits and register index width at 5 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, active-low, synchronous
- RegWriteE  in  1  register-write enable for this instruction
- ALUSrcE  in  1  ALU operand B select: 0 = forwarded register value, 1 = Imm_Ext_E
- MemWriteE  in  1  store enable
- ResultSrcE  in  1  writeback select (0 = ALU result, 1 = memory data), passed through
- BranchE  in  1  instruction is a conditional branch (beq)
- ALUControlE  in  3  ALU operation
- RD1_E  in  32  register-file read data for rs1
- RD2_E  in  32  register-file read data for rs2
- Imm_Ext_E  in  32  sign-extended immediate
- RD_E  in  5  destination register index
- PCE  in  32  PC of this instruction
- PCPlus4E  in  32  PC+4
- ResultW  in  32  writeback-stage result, used for forwarding
- ForwardA_E  in  2  forwarding select for operand A
- ForwardB_E  in  2  forwarding select for operand B
- PCSrcE  out  1  branch taken (combinational)
- PCTargetE  out  32  branch target (combinational)
- RegWriteM  out  1  registered RegWriteE
- MemWriteM  out  1  registered MemWriteE
- ResultSrcM  out  1  registered ResultSrcE
- RD_M  out  5  registered RD_E
- PCPlus4M  out  32  registered PCPlus4E
- WriteDataM  out  32  registered forwarded operand B (pre-ALUSrc mux)
- ALU_ResultM  out  32  registered ALU result

Behaviour:
- Operand A select:
  - ForwardA_E 00 → RD1_E
  - 01 → ResultW
  - 10 → ALU_ResultM (current registered output)
  - 11 → RD1_E
- Forwarded B (FB) uses the same encoding on ForwardB_E with RD2_E.
- SrcB = ALUSrcE ? Imm_Ext_E : FB.
- ALU operations, 32-bit, wrap-around, no traps:
  - ALUControlE 000: A+SrcB
  - 001: A−SrcB
  - 010: A & SrcB
  - 011: A | SrcB
  - 101: signed less-than (Result = 1 if (A−SrcB) is negative XOR overflow, else 0)
  - all other codes: 0
- ZeroE = (ALU result == 0), evaluated combinationally for every operation.
- PCSrcE = ZeroE & BranchE, purely combinational, valid in the same cycle as the inputs.
- PCTargetE = PCE + Imm_Ext_E, combinational, modulo 2^32. Computed regardless of BranchE.
- EX/MEM register (RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM):
  - Loads on every rising clk edge while rst=1.
  - Latency: exactly 1 cycle.
  - No stall or flush inputs.
- Reset: on a rising edge with rst=0, all registered outputs are cleared to 0. Reset takes priority over loading.
- Reset mid-operation: in-flight EX/MEM contents are discarded. PCSrcE and PCTargetE keep following the inputs during reset.
- Forwarding from ALU_ResultM uses the value held before the edge, so back-to-back dependencies resolve with no extra cycle.
- Unknown/X inputs are not sanitized; behaviour is defined only for known values.

Test Plan:
- Reset:
  - Stimulus: rst=0 for 2 edges with arbitrary inputs.
  - Response: all *M outputs = 0. Then rst=1 → outputs load on the next edge.
- ADD with immediate:
  - Stimulus: RegWriteE=1, ALUSrcE=1, ALUControlE=000, RD1_E=1, RD2_E=2, Imm_Ext_E=3, RD_E=1, PCE=0, PCPlus4E=4, Forward=00.
  - Response after 1 edge: ALU_ResultM=4, WriteDataM=2, RD_M=1, RegWriteM=1, PCPlus4M=4.
  - PCTargetE=3 immediately; PCSrcE=0.
- AND with immediate:
  - Stimulus: same inputs, ALUControlE=010.
  - Response: ALU_ResultM=1 (1&3). Repeat with 011 → 3, with 001 → 0xFFFFFFFE.
- Branch:
  - Stimulus: BranchE=1, ALUSrcE=0, ALUControlE=001, RD1_E=RD2_E=5, PCE=0x100, Imm_Ext_E=0x10.
  - Response: PCSrcE=1, PCTargetE=0x110. With RD2_E=6 → PCSrcE=0.
- Forwarding:
  - Stimulus: ALU_ResultM=4 from the previous cycle, ResultW=7; ForwardA_E=10, ForwardB_E=01, ALUSrcE=0, ALUControlE=000.
  - Response: ALU_ResultM=11, WriteDataM=7.
- SLT:
  - Stimulus: RD1_E=0xFFFFFFFF, SrcB=1, ALUControlE=101.
  - Response: ALU_ResultM=1. With RD1_E=2 → 0.

Source files
------------

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline.
// Contains operand forwarding, the ALU, beq resolution, and the EX/MEM pipeline register.
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] ResultW,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] PCPlus4M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALU_ResultM
);

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] diff;
    logic        overflow;
    logic [31:0] alu_result;
    logic        zero;

    // Forwarding selects 2'b10 from the EX/MEM register output, so a
    // back-to-back dependency uses the previous instruction's result.
    always_comb begin
        src_a = RD1_E;
        case (ForwardA_E)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALU_ResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALU_ResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    // Signed less-than is the sign of the difference, corrected for overflow.
    assign diff     = src_a - src_b;
    assign overflow = (src_a[31] != src_b[31]) && (diff[31] != src_a[31]);

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = diff;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = {31'd0, diff[31] ^ overflow};
            default: alu_result = '0;
        endcase
    end

    assign zero      = (alu_result == '0);
    assign PCSrcE    = zero & BranchE;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= fwd_b;
            ALU_ResultM <= alu_result;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle.
// Directed test-plan steps are followed by randomized steps, all checked against a behavioural model.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    int checks = 0;
    int errors = 0;

    // Model of the EX/MEM register contents
    logic        m_regwrite, m_memwrite, m_resultsrc;
    logic [4:0]  m_rd;
    logic [31:0] m_pcplus4, m_wdata, m_alu;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val,
                                         input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return reg_val;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Inputs are already driven; check the combinational outputs, clock once, then check the register.
    task automatic apply();
        logic [31:0] a, fb, b, res;
        a   = pick(ForwardA_E, RD1_E, ResultW, m_alu);
        fb  = pick(ForwardB_E, RD2_E, ResultW, m_alu);
        b   = ALUSrcE ? Imm_Ext_E : fb;
        res = ref_alu(ALUControlE, a, b);
        #1;
        chk("PCTargetE", PCTargetE, PCE + Imm_Ext_E);
        chk("PCSrcE", {31'd0, PCSrcE}, {31'd0, BranchE && (res == 32'd0)});
        @(posedge clk);
        if (!rst) begin
            m_regwrite = 0; m_memwrite = 0; m_resultsrc = 0; m_rd = 0;
            m_pcplus4 = 0; m_wdata = 0; m_alu = 0;
        end else begin
            m_regwrite = RegWriteE; m_memwrite = MemWriteE; m_resultsrc = ResultSrcE;
            m_rd = RD_E; m_pcplus4 = PCPlus4E; m_wdata = fb; m_alu = res;
        end
        #1;
        chk("RegWriteM", {31'd0, RegWriteM}, {31'd0, m_regwrite});
        chk("MemWriteM", {31'd0, MemWriteM}, {31'd0, m_memwrite});
        chk("ResultSrcM", {31'd0, ResultSrcM}, {31'd0, m_resultsrc});
        chk("RD_M", {27'd0, RD_M}, {27'd0, m_rd});
        chk("PCPlus4M", PCPlus4M, m_pcplus4);
        chk("WriteDataM", WriteDataM, m_wdata);
        chk("ALU_ResultM", ALU_ResultM, m_alu);
    endtask

    task automatic randomize_inputs();
        RegWriteE   = 1'($urandom);
        ALUSrcE     = 1'($urandom);
        MemWriteE   = 1'($urandom);
        ResultSrcE  = 1'($urandom);
        BranchE     = 1'($urandom);
        ALUControlE = 3'($urandom);
        RD1_E       = $urandom;
        RD2_E       = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
        Imm_Ext_E   = $urandom;
        RD_E        = 5'($urandom);
        PCE         = $urandom;
        PCPlus4E    = PCE + 32'd4;
        ResultW     = $urandom;
        ForwardA_E  = 2'($urandom);
        ForwardB_E  = 2'($urandom);
    endtask

    task automatic set_basic();
        RegWriteE = 1; ALUSrcE = 1; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
        ALUControlE = 3'b000; RD1_E = 1; RD2_E = 2; Imm_Ext_E = 3; RD_E = 1;
        PCE = 0; PCPlus4E = 4; ResultW = 0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    endtask

    initial begin
        m_regwrite = 0; m_memwrite = 0; m_resultsrc = 0; m_rd = 0;
        m_pcplus4 = 0; m_wdata = 0; m_alu = 0;

        // Reset for two edges with arbitrary inputs
        rst = 0;
        randomize_inputs();
        @(posedge clk); #1;
        apply();
        chk("reset_alu", ALU_ResultM, 32'd0);
        chk("reset_pcplus4", PCPlus4M, 32'd0);
        rst = 1;

        // ADD with immediate
        set_basic();
        #1;
        chk("add_target", PCTargetE, 32'd3);
        apply();
        chk("add_alu", ALU_ResultM, 32'd4);
        chk("add_wdata", WriteDataM, 32'd2);
        chk("add_rd", {27'd0, RD_M}, 32'd1);
        chk("add_pcplus4", PCPlus4M, 32'd4);

        // Forwarding: A from ALU_ResultM (4), B from ResultW (7)
        ALUSrcE = 0; ResultW = 7; ForwardA_E = 2'b10; ForwardB_E = 2'b01;
        apply();
        chk("fwd_alu", ALU_ResultM, 32'd11);
        chk("fwd_wdata", WriteDataM, 32'd7);

        set_basic(); ALUControlE = 3'b010; apply();
        chk("and_alu", ALU_ResultM, 32'd1);
        set_basic(); ALUControlE = 3'b011; apply();
        chk("or_alu", ALU_ResultM, 32'd3);
        set_basic(); ALUControlE = 3'b001; apply();
        chk("sub_alu", ALU_ResultM, 32'hFFFF_FFFE);

        // Branch equal / not equal
        set_basic(); BranchE = 1; ALUSrcE = 0; ALUControlE = 3'b001;
        RD1_E = 5; RD2_E = 5; PCE = 32'h100; Imm_Ext_E = 32'h10;
        #1;
        chk("beq_taken", {31'd0, PCSrcE}, 32'd1);
        chk("beq_target", PCTargetE, 32'h110);
        apply();
        RD2_E = 6;
        #1;
        chk("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
        apply();

        // SLT
        set_basic(); ALUSrcE = 1; Imm_Ext_E = 1; ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF;
        apply();
        chk("slt_neg", ALU_ResultM, 32'd1);
        RD1_E = 2; apply();
        chk("slt_pos", ALU_ResultM, 32'd0);
        RD1_E = 32'h8000_0000; Imm_Ext_E = 32'h7FFF_FFFF; apply();
        chk("slt_ovf", ALU_ResultM, 32'd1);

        // Randomized steps with occasional mid-run reset
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 19) != 0);
            apply();
        end
        rst = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
